// File: rtl/invader_field_if.sv
// Bullet/collision handshake between the player bullet logic and the
// invader formation: the bullet side presents its position, the formation
// answers with a one-cycle hit pulse that retires the bullet.
interface invader_field_if;
   logic       bullet_flying;
   logic [4:0] bullet_x;
   logic [3:0] bullet_y;
   logic       hit;

   modport master (output bullet_flying, output bullet_x, output bullet_y, input hit);
   modport slave  (input bullet_flying, input bullet_x, input bullet_y, output hit);
endinterface

// File: rtl/invader_field.sv
// Invader formation: alive bitmap, left/right march with a row drop at each
// edge, bullet collision with one-cycle hit pulse, score and wave status.
module invader_field #(
   parameter int unsigned ROWS     = 4,
   parameter int unsigned COLS     = 8,
   parameter int unsigned STEP_DIV = 8,
   parameter int unsigned GRID_W   = 32,
   parameter int unsigned LAND_ROW = 12
) (
   input  logic                 clk_36MHz,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 tick,
   input  logic                 restart,
   invader_field_if.slave       bullet_bus,
   output logic [ROWS*COLS-1:0] alive,
   output logic [4:0]           formation_x,
   output logic [3:0]           formation_y,
   output logic [1:0]           state,
   output logic [7:0]           score
);

   typedef enum logic [1:0] {
      ST_PLAY     = 2'd0,
      ST_CLEARED  = 2'd1,
      ST_INVADED  = 2'd2
   } wave_state_e;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } march_dir_e;

   // Rightmost legal fx: the full formation width always counts, even when
   // the outer columns are already destroyed.
   localparam logic [4:0] FX_MAX     = 5'(GRID_W - (2 * COLS - 1));
   localparam logic [7:0] PRESC_LAST = 8'(STEP_DIV - 1);

   logic [ROWS*COLS-1:0] alive_q, alive_d;
   logic [4:0]           fx_q, fx_d;
   logic [3:0]           fy_q, fy_d;
   logic [7:0]           score_q, score_d;
   logic [7:0]           presc_q, presc_d;
   logic                 hit_q, hit_d;
   march_dir_e           dir_q, dir_d;
   wave_state_e          state_q, state_d;

   logic                 match;
   logic [ROWS*COLS-1:0] kill_mask;

   // Collision detect against the current (pre-step) formation position.
   // Comparing bullet == origin + offset in widened arithmetic means a bullet
   // left of or above the formation can never alias onto a cell.
   always_comb begin
      match     = 1'b0;
      kill_mask = '0;
      if (bullet_bus.bullet_flying) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
               if (({2'b00, bullet_bus.bullet_y} == {2'b00, fy_q} + 6'(r)) &&
                   ({1'b0, bullet_bus.bullet_x} == {1'b0, fx_q} + 6'(2 * c)) &&
                   alive_q[r*COLS+c]) begin
                  match               = 1'b1;
                  kill_mask[r*COLS+c] = 1'b1;
               end
            end
         end
      end
   end

   // Next-state: restart reload, then hit and march updates, then the wave
   // status evaluated on the updated bitmap and row.
   always_comb begin
      alive_d = alive_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      score_d = score_q;
      presc_d = presc_q;
      dir_d   = dir_q;
      state_d = state_q;
      hit_d   = 1'b0;

      if (restart) begin
         alive_d = '1;
         fx_d    = '0;
         fy_d    = '0;
         score_d = '0;
         presc_d = '0;
         dir_d   = DIR_RIGHT;
         state_d = ST_PLAY;
      end else if (enable && (state_q == ST_PLAY)) begin
         if (match) begin
            hit_d   = 1'b1;
            alive_d = alive_q & ~kill_mask;
            score_d = score_q + 8'd1;
         end

         if (tick) begin
            if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               if ((dir_q == DIR_RIGHT) && (fx_q < FX_MAX)) begin
                  fx_d = fx_q + 5'd1;
               end else if ((dir_q == DIR_LEFT) && (fx_q != '0)) begin
                  fx_d = fx_q - 5'd1;
               end else begin
                  fy_d  = fy_q + 4'd1;
                  dir_d = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
               end
            end else begin
               presc_d = presc_q + 8'd1;
            end
         end

         if (alive_d == '0) begin
            state_d = ST_CLEARED;
         end else if ((6'(fy_d) + 6'(ROWS - 1)) >= 6'(LAND_ROW)) begin
            state_d = ST_INVADED;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_36MHz or negedge reset) begin
      if (!reset) begin
         alive_q <= '1;
         fx_q    <= '0;
         fy_q    <= '0;
         score_q <= '0;
         presc_q <= '0;
         dir_q   <= DIR_RIGHT;
         state_q <= ST_PLAY;
         hit_q   <= 1'b0;
      end else begin
         alive_q <= alive_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
         score_q <= score_d;
         presc_q <= presc_d;
         dir_q   <= dir_d;
         state_q <= state_d;
         hit_q   <= hit_d;
      end
   end

   assign bullet_bus.hit = hit_q;
   assign alive          = alive_q;
   assign formation_x    = fx_q;
   assign formation_y    = fy_q;
   assign state          = state_q;
   assign score          = score_q;

endmodule
